// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg : shared opcodes, default width and divider state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arith_pkg;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] DIV = 2'b11;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

`default_nettype wire

// File: rtl/arith_divider_if.sv
// ---------------------------------------------------------------------------
// arith_divider_if : operand/result valid-ready bundle for arith_divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface arith_divider_if #(
    parameter int DATA_W = arith_pkg::DATA_W_DEF
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [2*DATA_W-1:0]   dividend;
    logic [DATA_W-1:0]     divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   quotient;
    logic [DATA_W-1:0]     remainder;
    logic                  dbz;
    logic                  ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dbz, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dbz, ovf
    );

endinterface

`default_nettype wire

// File: rtl/arith_div_step.sv
// ---------------------------------------------------------------------------
// arith_div_step : one combinational restoring-division step on magnitudes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arith_div_step #(
    parameter int DATA_W = 16
) (
    input  wire logic [DATA_W:0] rem_i,
    input  wire logic            bit_i,
    input  wire logic [DATA_W:0] dvs_i,
    output logic      [DATA_W:0] rem_o,
    output logic                 qbit_o
);

    logic [DATA_W+1:0] w_shift;
    logic [DATA_W+1:0] w_diff;

    assign w_shift = {rem_i, bit_i};
    assign w_diff  = w_shift - {1'b0, dvs_i};
    assign qbit_o  = ~w_diff[DATA_W+1];
    assign rem_o   = qbit_o ? w_diff[DATA_W:0] : w_shift[DATA_W:0];

endmodule

`default_nettype wire

// File: rtl/arith_divider.sv
// ---------------------------------------------------------------------------
// arith_divider : sequential signed radix-2 restoring divider (2W / W bits)
// Optional macro ARITH_DIV_EARLY_EXIT_EN skips CALC for trivial operands.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arith_divider
    import arith_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    arith_divider_if.slave   bus_io
);

    localparam int QW = 2 * DATA_W;
    localparam int CW = $clog2(QW);

    div_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [QW-1:0]       quo_q;
    logic [DATA_W:0]     rem_q;
    logic [DATA_W:0]     dvs_q;
    logic                qneg_q, rneg_q, dbz_q, ovf_q;
    logic [QW-1:0]       quotient_q;
    logic [DATA_W-1:0]   remainder_q;
    logic                dbz_out_q, ovf_out_q;

    logic [QW:0]         w_dvd_mag;
    logic [DATA_W:0]     w_dvs_mag;
    logic                w_accept, w_dbz, w_ovf, w_short, w_qbit;
    logic [DATA_W:0]     w_rem_nxt;

    // One extra bit so the most-negative dividend has a representable magnitude
    assign w_dvd_mag = bus_io.dividend[QW-1] ? -{1'b1, bus_io.dividend}
                                             :  {1'b0, bus_io.dividend};
    assign w_dvs_mag = bus_io.divisor[DATA_W-1] ? -{1'b1, bus_io.divisor}
                                                :  {1'b0, bus_io.divisor};
    assign w_dbz     = (bus_io.divisor == '0);
    assign w_ovf     = (bus_io.dividend == {1'b1, {(QW-1){1'b0}}}) && (bus_io.divisor == '1);
    assign w_accept  = bus_io.in_valid && (state_q == IDLE);

`ifdef ARITH_DIV_EARLY_EXIT_EN
    assign w_short = w_dbz || (w_dvd_mag < {{DATA_W{1'b0}}, w_dvs_mag});
`else
    assign w_short = 1'b0;
`endif

    arith_div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i  (rem_q),
        .bit_i  (quo_q[QW-1]),
        .dvs_i  (dvs_q),
        .rem_o  (w_rem_nxt),
        .qbit_o (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus_io.in_valid) state_d = w_short ? FIX : CALC;
            CALC:    if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (bus_io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_out_q   <= 1'b0;
            ovf_out_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (w_accept) begin
                    dvs_q  <= w_dvs_mag;
                    qneg_q <= bus_io.dividend[QW-1] ^ bus_io.divisor[DATA_W-1];
                    rneg_q <= bus_io.dividend[QW-1];
                    dbz_q  <= w_dbz;
                    ovf_q  <= w_ovf;
                    cnt_q  <= CW'(QW - 1);
                    // A short operand is already its own remainder with a zero quotient
                    if (w_short) begin
                        quo_q <= '0;
                        rem_q <= w_dvd_mag[DATA_W:0];
                    end else begin
                        quo_q <= w_dvd_mag[QW-1:0];
                        rem_q <= {{DATA_W{1'b0}}, w_dvd_mag[QW]};
                    end
                end
                CALC: begin
                    quo_q <= {quo_q[QW-2:0], w_qbit};
                    rem_q <= w_rem_nxt;
                    cnt_q <= cnt_q - 1'b1;
                end
                FIX: begin
                    dbz_out_q <= dbz_q;
                    ovf_out_q <= ovf_q;
                    if (dbz_q) begin
                        quotient_q  <= '1;
                        remainder_q <= '0;
                    end else if (ovf_q) begin
                        quotient_q  <= {1'b1, {(QW-1){1'b0}}};
                        remainder_q <= '0;
                    end else begin
                        quotient_q  <= qneg_q ? -quo_q : quo_q;
                        remainder_q <= rneg_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_io.in_ready  = (state_q == IDLE);
    assign bus_io.out_valid = (state_q == DONE);
    assign bus_io.quotient  = quotient_q;
    assign bus_io.remainder = remainder_q;
    assign bus_io.dbz       = dbz_out_q;
    assign bus_io.ovf       = ovf_out_q;

endmodule

`default_nettype wire

// File: tb/tb_arith_divider.sv
// ---------------------------------------------------------------------------
// tb_arith_divider : self-checking bench for arith_divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_arith_divider;

    localparam int W = 16;
`ifdef ARITH_DIV_EARLY_EXIT_EN
    localparam int SHORT_LAT = 2;
`else
    localparam int SHORT_LAT = 34;
`endif
    localparam int FULL_LAT = 34;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arith_divider_if #(.DATA_W(W)) bus ();
    arith_divider #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: plain signed integer division with the two special cases
    function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                    output logic [31:0] q, output logic [15:0] r,
                                    output logic z, output logic o, output int lat);
        longint sa, sb, qt, rt, ma, mb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        z = 1'b0;
        o = 1'b0;
        if (sb == 0) begin
            q = '1; r = '0; z = 1'b1;
        end else if (a == 32'h8000_0000 && sb == -1) begin
            q = 32'h8000_0000; r = '0; o = 1'b1;
        end else begin
            qt = sa / sb;
            rt = sa % sb;
            q  = qt[31:0];
            r  = rt[15:0];
        end
        lat = (sb == 0 || ma < mb) ? SHORT_LAT : FULL_LAT;
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [15:0] b,
                           output logic [31:0] q, output logic [15:0] r,
                           output logic z, output logic o, output int lat);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        q = bus.quotient;
        r = bus.remainder;
        z = bus.dbz;
        o = bus.ovf;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready got %b want 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.quotient !== 32'h0) $display("FAIL reset quotient got %h want 0", bus.quotient); else n_pass++;
        n_checks++; if (bus.remainder !== 16'h0) $display("FAIL reset remainder got %h want 0", bus.remainder); else n_pass++;
        n_checks++; if ({bus.dbz, bus.ovf} !== 2'b00) $display("FAIL reset flags got %b want 00", {bus.dbz, bus.ovf}); else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] da [7] = '{32'd1000, 32'hFFFF_FC18, 32'd1000, 32'd5, 32'h8000_0000, 32'd3, 32'hFFFF_FFF9};
        logic [15:0] db [7] = '{16'd7, 16'd7, 16'hFFF9, 16'd0, 16'hFFFF, 16'd100, 16'd100};
        logic [31:0] eq [7] = '{32'd142, 32'hFFFF_FF72, 32'hFFFF_FF72, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd0};
        logic [15:0] er [7] = '{16'd6, 16'hFFFA, 16'd6, 16'd0, 16'd0, 16'd3, 16'hFFF9};
        logic        ez [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        eo [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int          el [7] = '{FULL_LAT, FULL_LAT, FULL_LAT, SHORT_LAT, FULL_LAT, SHORT_LAT, SHORT_LAT};
        logic [31:0] q;
        logic [15:0] r;
        logic        z, o;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            run_div(da[i], db[i], q, r, z, o, lat);
            n_checks++; if (q !== eq[i]) $display("FAIL dir[%0d] quotient got %h want %h", i, q, eq[i]); else n_pass++;
            n_checks++; if (r !== er[i]) $display("FAIL dir[%0d] remainder got %h want %h", i, r, er[i]); else n_pass++;
            n_checks++; if (z !== ez[i]) $display("FAIL dir[%0d] dbz got %b want %b", i, z, ez[i]); else n_pass++;
            n_checks++; if (o !== eo[i]) $display("FAIL dir[%0d] ovf got %b want %b", i, o, eo[i]); else n_pass++;
            n_checks++; if (lat !== el[i]) $display("FAIL dir[%0d] latency got %0d want %0d", i, lat, el[i]); else n_pass++;
            take_result();
        end
    endtask

    task automatic test_backpressure();
        int busy_bad   = 0;
        int stable_bad = 0;
        int cyc        = 0;
        bus.dividend = 32'd100;
        bus.divisor  = 16'd3;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (bus.out_valid !== 1'b1 && cyc < 200) begin
            bus.in_valid = (cyc % 3 == 0);
            bus.dividend = $urandom;
            bus.divisor  = 16'd1;
            @(posedge clk); #1;
            if (bus.in_ready !== 1'b0) busy_bad++;
            cyc++;
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.quotient !== 32'd33 || bus.remainder !== 16'd1
                || bus.in_ready !== 1'b0) stable_bad++;
        end
        bus.in_valid = 1'b0;
        n_checks++; if (busy_bad != 0) $display("FAIL bp busy in_ready got %0d high cycles want 0", busy_bad); else n_pass++;
        n_checks++; if (stable_bad != 0) $display("FAIL bp hold got %0d unstable cycles want 0", stable_bad); else n_pass++;
        n_checks++; if (bus.quotient !== 32'd33) $display("FAIL bp quotient got %0d want 33", bus.quotient); else n_pass++;
        n_checks++; if (bus.remainder !== 16'd1) $display("FAIL bp remainder got %0d want 1", bus.remainder); else n_pass++;
        take_result();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp post out_valid got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp post in_ready got %b want 1", bus.in_ready); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp ghost out_valid got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        bus.dividend = 32'd1000;
        bus.divisor  = 16'd7;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL abort out_valid got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.quotient !== 32'h0) $display("FAIL abort quotient got %h want 0", bus.quotient); else n_pass++;
        n_checks++; if (bus.remainder !== 16'h0) $display("FAIL abort remainder got %h want 0", bus.remainder); else n_pass++;
        @(posedge clk); #3 rst_n = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL abort in_ready got %b want 1", bus.in_ready); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL abort stale result got %0d valid cycles want 0", seen); else n_pass++;
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] a, q, eq;
        logic [15:0] b, r, er, t;
        logic        z, o, ez, eo;
        int          lat, el, sel;
        for (int n = 0; n < 150; n++) begin
            a   = $urandom;
            b   = 16'($urandom);
            sel = $urandom_range(0, 5);
            t   = 16'($urandom_range(1, 20));
            case (sel)
                1: b = t;
                2: b = -t;
                3: b = '0;
                4: begin b = '1; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
                5: a = {{16{t[4]}}, 16'($urandom)};
                default: ;
            endcase
            ref_div(a, b, eq, er, ez, eo, el);
            n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b[%0d] in_ready got %b want 1", n, bus.in_ready); else n_pass++;
            run_div(a, b, q, r, z, o, lat);
            n_checks++; if (q !== eq) $display("FAIL rnd[%0d] %h/%h quotient got %h want %h", n, a, b, q, eq); else n_pass++;
            n_checks++; if (r !== er) $display("FAIL rnd[%0d] %h/%h remainder got %h want %h", n, a, b, r, er); else n_pass++;
            n_checks++; if ({z, o} !== {ez, eo}) $display("FAIL rnd[%0d] %h/%h flags got %b want %b", n, a, b, {z, o}, {ez, eo}); else n_pass++;
            n_checks++; if (lat !== el) $display("FAIL rnd[%0d] %h/%h latency got %0d want %0d", n, a, b, lat, el); else n_pass++;
            take_result();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/arith_divider.md
Name: arith_divider

Overview:
- Sequential signed divider: the inverse of the existing add/sub/mul arithmetic unit.
- Takes a 32-bit signed dividend and a 16-bit signed divisor; returns a 32-bit quotient and a 16-bit remainder.
- Radix-2 restoring algorithm on magnitudes, one quotient bit per clock.
- Sits beside the arithmetic unit behind the same AXI-Lite register wrapper; selected by opcode 2'b11. Valid/ready handshake on both sides.

Parameters:
- DATA_W, 16, divisor/remainder width; dividend and quotient are 2*DATA_W bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  2*DATA_W  signed dividend
- divisor  input  DATA_W  signed divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  2*DATA_W  signed quotient, truncated toward zero
- remainder  output  DATA_W  signed remainder; sign follows the dividend
- dbz  output  1  divide-by-zero flag, valid with out_valid
- ovf  output  1  overflow flag (most-negative / -1), valid with out_valid

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1 after reset.
  - out_valid, quotient, remainder, dbz, ovf and all internal registers = 0.
  - Reset mid-operation aborts the division; no result is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register |dividend|, |divisor|, the result signs and the dbz/ovf conditions; load step counter = 2*DATA_W-1; go to CALC.
- CALC:
  - One restoring step per cycle: shift the partial remainder left, bring in the next dividend bit, subtract |divisor|.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore.
  - Counter decrements; at 0 go to FIX.
  - Exactly 2*DATA_W cycles in CALC.
- FIX:
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend is negative.
  - Apply the dbz/ovf overrides; go to DONE.
- DONE:
  - out_valid=1; outputs are held stable while out_ready=0.
  - On out_ready=1, return to IDLE with out_valid=0 on the next cycle.
- Latency: 2*DATA_W+2 cycles from the accept edge to out_valid (34 at default).
- Throughput: in_ready=0 in CALC/FIX/DONE, so in_valid is ignored while busy. No same-cycle accept during an output handshake; the next accept is possible at the earliest one cycle after out handshake.
- Width rules: magnitudes are unsigned (2*DATA_W+1) internally so that -2^(2*DATA_W-1) negates correctly.
- Divisor == 0: quotient = all-ones (-1), remainder = 0, dbz=1, ovf=0. Full latency unless the optional feature is enabled.
- Dividend == 0x80000000 and divisor == -1: quotient = 0x80000000 (wraps), remainder = 0, ovf=1, dbz=0.
- |dividend| < |divisor|: quotient = 0, remainder = dividend[DATA_W-1:0] (fits by definition).
- Flags remain 0 for all other cases.

Optional Feature:
- Macro: ARITH_DIV_EARLY_EXIT_EN
- Defined: at accept, if divisor==0 or |dividend|<|divisor|, go from IDLE directly to FIX. Latency becomes 2 cycles; results are identical to the non-early path.
- Undefined: latency is always 2*DATA_W+2; no comparator is built.

Decomposition:
- Package arith_pkg holds:
  - Opcode constants ADD=2'b00, SUB=2'b01, MUL=2'b10, DIV=2'b11.
  - DATA_W default.
  - State enum {IDLE, CALC, FIX, DONE}.
- One combinational sub-module, arith_div_step: inputs are the partial remainder, next dividend bit and |divisor|; outputs are the new partial remainder and the quotient bit.

Test Plan:
- 1000 / 7 -> quotient=142, remainder=6, dbz=0, ovf=0, out_valid exactly 34 cycles after accept.
- -1000 / 7 -> quotient=-142, remainder=-6.
- 1000 / -7 -> quotient=-142, remainder=6.
- 5 / 0 -> quotient=0xFFFFFFFF, remainder=0, dbz=1. Latency 34 without ARITH_DIV_EARLY_EXIT_EN, 2 with it.
- 0x80000000 / -1 -> quotient=0x80000000, remainder=0, ovf=1.
- 100 / 3 with out_ready low for 10 cycles -> outputs stable (33, 1). Concurrent in_valid pulses are ignored (in_ready=0). In a separate run, asserting rst_n=0 at cycle 10 of CALC clears all outputs immediately and in_ready returns to 1 after release.
